// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared encodings for the LED pattern engine
// Purpose: mode codes, FSM state encoding (one-hot) and bounce direction.
// Ports: none (package).
package led_pattern_pkg;

   localparam logic [2:0] MODE_ROT_L  = 3'd0;
   localparam logic [2:0] MODE_ROT_R  = 3'd1;
   localparam logic [2:0] MODE_CNT_UP = 3'd2;
   localparam logic [2:0] MODE_CNT_DN = 3'd3;
   localparam logic [2:0] MODE_STATIC = 3'd4;
   localparam logic [2:0] MODE_LFSR   = 3'd5;
   localparam logic [2:0] MODE_BOUNCE = 3'd6;
   localparam logic [2:0] MODE_RSVD   = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_ARM  = 3'b010,
      ST_RUN  = 3'b100
   } state_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

endpackage

// File: rtl/led_period_timer.sv
// rtl/led_period_timer.sv - reloadable step-period down-counter
// Purpose: counts down while run is high; zero flags the step cycle.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   reload      - load max(reload_val,1)-1 (wins over run)
//   reload_val  - period in cycles, 0 treated as 1
//   run         - decrement enable
//   zero        - counter is at 0
module led_period_timer
   import led_pattern_pkg::*;
#(
   parameter int                 TIMER_W      = 24,
   parameter logic [TIMER_W-1:0] RESET_PERIOD = 24'h2625A0
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               reload,
   input  logic [TIMER_W-1:0] reload_val,
   input  logic               run,
   output logic               zero
);

   localparam logic [TIMER_W-1:0] ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

   logic [TIMER_W-1:0] count;

   // A period of 0 behaves like 1, so both load a count of 0.
   function automatic logic [TIMER_W-1:0] clamp_m1(input logic [TIMER_W-1:0] p);
      return (p == '0) ? '0 : p - ONE;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= clamp_m1(RESET_PERIOD);
      end else if (reload) begin
         count <= clamp_m1(reload_val);
      end else if (run && count != '0) begin
         count <= count - ONE;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - parametrised multi-mode LED pattern engine
// Purpose: steps an N_LEDS pattern every max(period,1) cycles in one of
//          eight modes, with a synchronous pattern load.
// Ports:
//   CLK_50MHZ, RST - clock, async active-low reset
//   enable         - run when high, freeze when low
//   mode           - pattern mode, sampled at each step
//   period         - step period in cycles (0 treated as 1)
//   load_strobe    - one-cycle load request for load_value
//   load_value     - pattern to load
//   pattern        - current pattern register
//   led_on         - pattern delayed one cycle, 1 = LED lit
//   step_tick      - one-cycle pulse with each new stepped pattern
//   running        - high while in RUN
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int                 N_LEDS         = 8,
   parameter int                 TIMER_W        = 24,
   parameter logic [TIMER_W-1:0] DEFAULT_PERIOD = 24'h2625A0,
   parameter logic [N_LEDS-1:0]  RESET_PATTERN  = 8'h01,
   parameter logic [N_LEDS-1:0]  LFSR_TAPS      = 8'hB8
)(
   input  logic               CLK_50MHZ,
   input  logic               RST,
   input  logic               enable,
   input  logic [2:0]         mode,
   input  logic [TIMER_W-1:0] period,
   input  logic               load_strobe,
   input  logic [N_LEDS-1:0]  load_value,
   output logic [N_LEDS-1:0]  pattern,
   output logic [N_LEDS-1:0]  led_on,
   output logic               step_tick,
   output logic               running
);

   localparam logic [N_LEDS-1:0] ONE_P = {{(N_LEDS-1){1'b0}}, 1'b1};

   state_t            state, state_nx;
   dir_t              dir;
   logic              tmr_reload, tmr_run, tmr_zero, do_step;
   logic [N_LEDS:0]   step_result;

   // Returns {next_dir, next_pattern}.
   function automatic logic [N_LEDS:0] step_pattern(input logic [N_LEDS-1:0] p,
                                                    input logic [2:0]        m,
                                                    input dir_t              d);
      logic [N_LEDS-1:0] np;
      dir_t              nd;
      dir_t              eff;
      np  = p;
      nd  = d;
      eff = d;
      case (m)
         MODE_ROT_L:  np = {p[N_LEDS-2:0], p[N_LEDS-1]};
         MODE_ROT_R:  np = {p[0], p[N_LEDS-1:1]};
         MODE_CNT_UP: np = p + ONE_P;
         MODE_CNT_DN: np = p - ONE_P;
         MODE_LFSR: begin
            // All-zero is the LFSR lock-up state; reseed with 1.
            if (p == '0)   np = ONE_P;
            else if (p[0]) np = (p >> 1) ^ LFSR_TAPS;
            else           np = p >> 1;
         end
         MODE_BOUNCE: begin
            if (p == '0 || (p & (p - ONE_P)) != '0) begin
               np = ONE_P;
               nd = DIR_LEFT;
            end else begin
               // A lit bit sitting at an end always moves inward, even if
               // dir is stale (e.g. after a load).
               if (p[N_LEDS-1]) eff = DIR_RIGHT;
               else if (p[0])   eff = DIR_LEFT;
               np = (eff == DIR_LEFT) ? (p << 1) : (p >> 1);
               if (np[N_LEDS-1]) nd = DIR_RIGHT;
               else if (np[0])   nd = DIR_LEFT;
               else              nd = eff;
            end
         end
         default: np = p;
      endcase
      return {nd, np};
   endfunction

   assign step_result = step_pattern(pattern, mode, dir);

   led_period_timer #(
      .TIMER_W      (TIMER_W),
      .RESET_PERIOD (DEFAULT_PERIOD)
   ) u_timer (
      .clk        (CLK_50MHZ),
      .rst_n      (RST),
      .reload     (tmr_reload),
      .reload_val (period),
      .run        (tmr_run),
      .zero       (tmr_zero)
   );

   always_comb begin
      state_nx   = state;
      tmr_reload = 1'b0;
      tmr_run    = 1'b0;
      do_step    = 1'b0;
      case (state)
         ST_IDLE: if (enable) state_nx = ST_ARM;
         ST_ARM: begin
            state_nx   = ST_RUN;
            tmr_reload = 1'b1;
         end
         ST_RUN: begin
            if (!enable) begin
               state_nx = ST_IDLE;
            end else begin
               tmr_run = 1'b1;
               // A load restarts the phase and suppresses a coincident step.
               if (load_strobe) begin
                  tmr_reload = 1'b1;
               end else if (tmr_zero) begin
                  do_step    = 1'b1;
                  tmr_reload = 1'b1;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_50MHZ or negedge RST) begin
      if (!RST) begin
         state     <= ST_IDLE;
         pattern   <= RESET_PATTERN;
         led_on    <= '0;
         step_tick <= 1'b0;
         running   <= 1'b0;
         dir       <= DIR_LEFT;
      end else begin
         state     <= state_nx;
         running   <= (state_nx == ST_RUN);
         led_on    <= pattern;
         step_tick <= do_step;
         if (load_strobe) begin
            pattern <= load_value;
         end else if (do_step) begin
            pattern <= step_result[N_LEDS-1:0];
            dir     <= dir_t'(step_result[N_LEDS]);
         end
      end
   end

endmodule
